// File: rtl/mypipeslice.sv
// ============================================================================
// Module   : mypipeslice
// Purpose  : valid/ready pipeline slice with selectable forward, backward or
//            full register boundary, synchronous flush and occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mypipeslice_dreg #(
    parameter int DW   = 32,
    parameter     NAME = "mypipeslice_dreg"
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);
    localparam int c_TAG_BITS = $bits(NAME);

    // Payload storage is deliberately reset-free; only the valid flags carry state.
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_q <= i_d;
        end
    end

    generate
        if (c_TAG_BITS == 0) begin : g_untagged
        end
    endgenerate
endmodule

module mypipeslice #(
    parameter int DW   = 32,
    parameter int MODE = 3,
    parameter     NAME = "mypipeslice"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] data_i,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] data_o,
    output logic [1:0]    occ
);
    generate
        if (MODE == 0) begin : g_pass
            assign o_vld  = i_vld;
            assign data_o = data_i;
            assign i_rdy  = o_rdy;
            assign occ    = 2'd0;

        end else if (MODE == 1) begin : g_fwd
            logic          r_ov;
            logic [DW-1:0] r_od;
            logic          w_acc;

            assign i_rdy = rst & (~r_ov | o_rdy);
            assign w_acc = i_rdy & i_vld;

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    r_ov <= 1'b0;
                end else if (i_rdy) begin
                    r_ov <= i_vld;
                end
            end

            mypipeslice_dreg #(.DW(DW), .NAME(NAME)) u_od (
                .clk  (clk),
                .i_en (w_acc),
                .i_d  (data_i),
                .o_q  (r_od)
            );

            assign o_vld  = r_ov;
            assign data_o = r_od;
            assign occ    = {1'b0, r_ov};

        end else if (MODE == 2) begin : g_skid
            logic          r_sv;
            logic [DW-1:0] r_sd;
            logic          w_cap;

            assign i_rdy = rst & ~r_sv;
            // A beat is only parked when downstream stalls it on its way through.
            assign w_cap = i_vld & i_rdy & ~o_rdy;

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    r_sv <= 1'b0;
                end else if (w_cap) begin
                    r_sv <= 1'b1;
                end else if (r_sv && o_rdy) begin
                    r_sv <= 1'b0;
                end
            end

            mypipeslice_dreg #(.DW(DW), .NAME(NAME)) u_sd (
                .clk  (clk),
                .i_en (w_cap),
                .i_d  (data_i),
                .o_q  (r_sd)
            );

            assign o_vld  = r_sv | (i_vld & rst);
            assign data_o = r_sv ? r_sd : data_i;
            assign occ    = {1'b0, r_sv};

        end else begin : g_full
            logic          r_mv;
            logic          r_sv;
            logic [DW-1:0] r_md;
            logic [DW-1:0] r_sd;
            logic          w_acc;
            logic          w_pop;
            logic          w_mv_nxt;
            logic          w_sv_nxt;
            logic          w_md_en;
            logic          w_md_from_skid;
            logic          w_sd_en;
            logic [DW-1:0] w_md_d;

            assign i_rdy = rst & ~r_sv;
            assign w_acc = i_vld & i_rdy;
            assign w_pop = r_mv & o_rdy;

            // The main register always holds the oldest beat; the skid only
            // fills when main is occupied and not draining.
            always_comb begin
                w_mv_nxt       = r_mv;
                w_sv_nxt       = r_sv;
                w_md_en        = 1'b0;
                w_md_from_skid = 1'b0;
                w_sd_en        = 1'b0;
                if (!r_mv) begin
                    if (w_acc) begin
                        w_mv_nxt = 1'b1;
                        w_md_en  = 1'b1;
                    end
                end else if (w_pop) begin
                    if (r_sv) begin
                        w_md_en        = 1'b1;
                        w_md_from_skid = 1'b1;
                        w_sv_nxt       = 1'b0;
                    end else if (w_acc) begin
                        w_md_en = 1'b1;
                    end else begin
                        w_mv_nxt = 1'b0;
                    end
                end else if (w_acc) begin
                    w_sv_nxt = 1'b1;
                    w_sd_en  = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    r_mv <= 1'b0;
                    r_sv <= 1'b0;
                end else begin
                    r_mv <= w_mv_nxt;
                    r_sv <= w_sv_nxt;
                end
            end

            assign w_md_d = w_md_from_skid ? r_sd : data_i;

            mypipeslice_dreg #(.DW(DW), .NAME(NAME)) u_md (
                .clk  (clk),
                .i_en (w_md_en),
                .i_d  (w_md_d),
                .o_q  (r_md)
            );

            mypipeslice_dreg #(.DW(DW), .NAME(NAME)) u_sd (
                .clk  (clk),
                .i_en (w_sd_en),
                .i_d  (data_i),
                .o_q  (r_sd)
            );

            assign o_vld  = r_mv;
            assign data_o = r_md;
            assign occ    = {1'b0, r_mv} + {1'b0, r_sv};
        end
    endgenerate
endmodule

`default_nettype wire

// File: tb/tb_mypipeslice.sv
// ============================================================================
// Module   : tb_mypipeslice
// Purpose  : scoreboard bench driving one slice instance of each MODE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mypipeslice;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        vld    [4];
    logic        rdy_up [4];
    logic        rdy_dn [4];
    logic        ov     [4];
    logic [31:0] din    [4];
    logic [31:0] dout   [4];
    logic [1:0]  occ    [4];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            mypipeslice #(.DW(32), .MODE(g), .NAME("slice")) u_dut (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .i_vld  (vld[g]),
                .i_rdy  (rdy_up[g]),
                .data_i (din[g]),
                .o_vld  (ov[g]),
                .o_rdy  (rdy_dn[g]),
                .data_o (dout[g]),
                .occ    (occ[g])
            );
        end
    endgenerate

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          act   = 0;
    logic [31:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshakes are stable between the falling edge and the next rising edge.
    always @(negedge clk) begin
        if (vld[act] && rdy_up[act]) sb.push_back(din[act]);
        if (ov[act] && rdy_dn[act]) begin
            n_pop++;
            chk("sb_beat_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) chk("sb_data", dout[act], sb.pop_front());
        end
        if (act != 0 && (flush || !rst)) sb.delete();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        m_sv;
        logic [31:0] d;
        int          n_acc;

        rst   = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld[i]    = 1'b0;
            rdy_dn[i] = 1'b0;
            din[i]    = 32'h0;
        end

        // Reset: ready held low during reset, high right after release
        settle();
        for (int i = 1; i < 4; i++) chk("rst_irdy_low", rdy_up[i], 1'b0);
        tick();
        rst = 1'b1;
        settle();
        for (int i = 1; i < 4; i++) begin
            chk("rst_ovld", ov[i], 1'b0);
            chk("rst_occ", occ[i], 2'd0);
            chk("rst_irdy_high", rdy_up[i], 1'b1);
        end
        tick();

        // MODE 3 back-to-back stream
        act = 3; n_pop = 0; rdy_dn[3] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            vld[3] = 1'b1;
            din[3] = k;
            settle();
            chk("A_irdy", rdy_up[3], 1'b1);
            chk("A_occ_le1", occ[3] <= 2'd1, 1'b1);
            if (k == 1) chk("A_latency_ovld0", ov[3], 1'b0);
            if (k == 2) begin
                chk("A_latency_ovld1", ov[3], 1'b1);
                chk("A_first_data", dout[3], 32'h1);
            end
            tick();
        end
        vld[3] = 1'b0;
        repeat (4) tick();
        chk("A_beats", n_pop, 16);
        chk("A_sb_empty", sb.size(), 0);

        // MODE 3 fill to two beats then drain
        rdy_dn[3] = 1'b0;
        vld[3] = 1'b1; din[3] = 32'hA5A5A5A5;
        tick();
        din[3] = 32'h5A5A5A5A;
        tick();
        vld[3] = 1'b0;
        settle();
        chk("B_occ2", occ[3], 2'd2);
        chk("B_irdy0", rdy_up[3], 1'b0);
        chk("B_head", dout[3], 32'hA5A5A5A5);
        tick();
        rdy_dn[3] = 1'b1;
        settle();
        chk("B_irdy_still0", rdy_up[3], 1'b0);
        tick();
        settle();
        chk("B_irdy1", rdy_up[3], 1'b1);
        chk("B_second", dout[3], 32'h5A5A5A5A);
        chk("B_ovld", ov[3], 1'b1);
        tick();
        settle();
        chk("B_empty", occ[3], 2'd0);
        tick();

        // MODE 2 skid with toggling downstream ready
        act = 2; n_pop = 0; m_sv = 1'b0; d = 32'h100; n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            vld[2]    = 1'b1;
            din[2]    = d;
            rdy_dn[2] = (c % 2 == 0);
            settle();
            chk("C_irdy", rdy_up[2], !m_sv);
            chk("C_occ", occ[2], {1'b0, m_sv});
            if (!m_sv) chk("C_passthru", dout[2], din[2]);
            if (!m_sv) begin
                n_acc++;
                d++;
                if (!rdy_dn[2]) m_sv = 1'b1;
            end else if (rdy_dn[2]) begin
                m_sv = 1'b0;
            end
            tick();
        end
        vld[2] = 1'b0; rdy_dn[2] = 1'b1;
        repeat (3) tick();
        chk("C_beats", n_pop, n_acc);
        chk("C_sb_empty", sb.size(), 0);

        // MODE 1 flush while holding a stalled beat
        act = 1; n_pop = 0; rdy_dn[1] = 1'b0;
        vld[1] = 1'b1; din[1] = 32'h1234;
        tick();
        vld[1] = 1'b0;
        settle();
        chk("D_held_vld", ov[1], 1'b1);
        chk("D_held_data", dout[1], 32'h1234);
        chk("D_held_occ", occ[1], 2'd1);
        tick();
        flush = 1'b1; vld[1] = 1'b1; din[1] = 32'hBEEF;
        tick();
        flush = 1'b0; vld[1] = 1'b0;
        settle();
        chk("D_flush_vld", ov[1], 1'b0);
        chk("D_flush_occ", occ[1], 2'd0);
        tick();
        rdy_dn[1] = 1'b1;
        repeat (3) tick();
        chk("D_nothing_out", n_pop, 0);
        vld[1] = 1'b1; din[1] = 32'h77;
        settle();
        chk("D_lat0", ov[1], 1'b0);
        tick();
        vld[1] = 1'b0;
        settle();
        chk("D_after_flush", dout[1], 32'h77);
        tick();
        tick();
        chk("D_sb_empty", sb.size(), 0);

        // MODE 3 reset while full
        act = 3; n_pop = 0; rdy_dn[3] = 1'b0;
        vld[3] = 1'b1; din[3] = 32'hC1;
        tick();
        din[3] = 32'hC2;
        tick();
        vld[3] = 1'b0;
        settle();
        chk("E_occ2", occ[3], 2'd2);
        tick();
        rst = 1'b0;
        settle();
        chk("E_irdy_in_rst", rdy_up[3], 1'b0);
        tick();
        rst = 1'b1;
        settle();
        chk("E_ovld", ov[3], 1'b0);
        chk("E_occ", occ[3], 2'd0);
        chk("E_irdy", rdy_up[3], 1'b1);
        tick();
        rdy_dn[3] = 1'b1;
        repeat (3) tick();
        chk("E_no_replay", n_pop, 0);

        // MODE 0 random passthrough
        act = 0;
        for (int c = 0; c < 20; c++) begin
            vld[0]    = 1'($urandom_range(1, 0));
            rdy_dn[0] = 1'($urandom_range(1, 0));
            din[0]    = $urandom;
            settle();
            chk("F_pass", {ov[0], rdy_up[0], dout[0], occ[0]},
                {vld[0], rdy_dn[0], din[0], 2'b00});
            tick();
        end
        vld[0] = 1'b0;
        tick();
        chk("F_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
